byte_packer: RTL

Packs a stream of 8-bit valid/ready beats into LANES-byte words on a registered valid/ready output. It sits directly upstream of the wide datapath and consumes the byte stream leaving the single-stage pipeline register. It sustains one byte per cycle with no bubbles while the downstream consumer keeps up. An optional flush lets a frame end on a partial word.

---
 rtl/pipe_pkg.sv | 6 +
 rtl/packer_out_reg.sv | 27 ++
 rtl/byte_packer.sv | 90 +++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the byte packing datapath
package pipe_pkg;
    typedef enum logic {ACCUM, HOLD} packer_state_t;
    localparam int LANES_MAX = 8;
    localparam int BYTE_W = 8;
endpackage

// File: rtl/packer_out_reg.sv
// packer_out_reg: single-entry valid/ready output register with load strobe and free indication
module packer_out_reg #(
    parameter int W = 37
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] q,
    output logic         free
);
    assign free = !valid || ready;
    // load wins over drain so a simultaneous load and handshake gives back-to-back words
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/byte_packer.sv
// byte_packer: packs 8-bit beats into LANES-byte words; BYTE_PACKER_FLUSH_EN enables in_last flush
module byte_packer
    import pipe_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BYTE_W-1:0]     in,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    output logic [BYTE_W*LANES-1:0] out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES-1:0]      out_keep,
    output logic                  out_last
);
    localparam int CW = $clog2(LANES);
    localparam int DW = BYTE_W * LANES;

    if ((LANES < 2) || (LANES > LANES_MAX)) begin : g_bad_lanes
        $error("byte_packer: LANES must be in 2..8");
    end

    packer_state_t          state, state_n;
    logic [DW-1:0]          acc, acc_n, merged, ld_word;
    logic [CW-1:0]          cnt, cnt_n;
    logic [LANES-1:0]       keep_mask;
    logic                   flush_in, out_free, load, ld_last, last_cnt, xfer, complete, hold;

`ifdef BYTE_PACKER_FLUSH_EN
    assign flush_in = in_last;
`else
    logic unused_last;
    assign unused_last = in_last;
    assign flush_in = 1'b0;
`endif

    assign hold     = state == HOLD;
    assign last_cnt = cnt == CW'(LANES - 1);
    assign in_ready = hold ? 1'b0 : (last_cnt ? out_free : 1'b1);
    assign xfer     = in_valid && in_ready;
    assign complete = last_cnt || flush_in;

    // accumulator with the incoming byte merged at lane cnt; lanes beyond cnt forced to zero
    always_comb begin
        merged    = '0;
        keep_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            merged[BYTE_W*i +: BYTE_W] = (i == int'(cnt)) ? in :
                                         (i < int'(cnt)) ? acc[BYTE_W*i +: BYTE_W] : '0;
            keep_mask[i] = i <= int'(cnt);
        end
    end

    // next-state: complete words go straight out when free, otherwise a flushed partial waits in HOLD
    always_comb begin
        load    = hold ? out_free : (xfer && complete && out_free);
        ld_last = hold || flush_in;
        ld_word = hold ? acc : merged;
        state_n = hold ? (out_free ? ACCUM : HOLD) : ((xfer && complete && !out_free) ? HOLD : ACCUM);
        cnt_n   = load ? '0 : ((xfer && !complete) ? cnt + CW'(1) : cnt);
        acc_n   = load ? '0 : (xfer ? merged : acc);
    end

    // state, lane counter and accumulator registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ACCUM;
            cnt   <= '0;
            acc   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            acc   <= acc_n;
        end
    end

    packer_out_reg #(.W(DW + LANES + 1)) u_out_reg (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .d     ({ld_word, keep_mask, ld_last}),
        .ready (out_ready),
        .valid (out_valid),
        .q     ({out, out_keep, out_last}),
        .free  (out_free)
    );
endmodule
